// File: rtl/exwb_arbiter_if.sv
// Execute-result and ROB-writeback bundle for exwb_arbiter.
// The slave side is the arbiter; the master side drives results and watches writebacks.
interface exwb_arbiter_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic [TAG_W-1:0]  alu_target;
  logic [DATA_W-1:0] alu_result;
  logic [TAG_W-1:0]  fwd_target;
  logic [DATA_W-1:0] fwd_result;
  logic [TAG_W-1:0]  jmp_target;
  logic [DATA_W-1:0] jmp_ori_pc;
  logic [DATA_W-1:0] jmp_next_pc;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_result;
  logic              wb_is_jump;
  logic [DATA_W-1:0] wb_next_pc;
  logic [2:0]        almost_full;
  logic              overflow_err;

  modport master (
    output alu_target, alu_result, fwd_target, fwd_result,
           jmp_target, jmp_ori_pc, jmp_next_pc,
    input  wb_valid, wb_tag, wb_result, wb_is_jump, wb_next_pc,
           almost_full, overflow_err
  );

  modport slave (
    input  alu_target, alu_result, fwd_target, fwd_result,
           jmp_target, jmp_ori_pc, jmp_next_pc,
    output wb_valid, wb_tag, wb_result, wb_is_jump, wb_next_pc,
           almost_full, overflow_err
  );
endinterface

// File: rtl/exwb_arbiter.sv
// Writeback arbiter: per-source FIFOs for ALU/forwarder/jump results,
// round-robin serialised onto the single registered ROB writeback port.
module exwb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         afull,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          full, wr_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign afull = (cnt >= (AW+1)'(DEPTH-1));
  // a full FIFO still accepts when its head leaves on the same edge
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) mem[wptr] <= din;
  end
endmodule

module exwb_arbiter #(
  parameter int               TAG_W       = 5,
  parameter int               DATA_W      = 32,
  parameter int               DEPTH       = 4,
  parameter logic [TAG_W-1:0] TAG_INVALID = '1
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  exwb_arbiter_if.slave bus
);
  localparam int NSRC  = 3;
  localparam int ENT_W = TAG_W + 2*DATA_W;

  logic [NSRC-1:0][TAG_W-1:0] tgt;
  logic [NSRC-1:0][ENT_W-1:0] din, dout;
  logic [NSRC-1:0]            push, pop, empty, afull, drop;
  logic [1:0]                 last_grant, gnt_id, cand;
  logic                       gnt_vld;
  logic [ENT_W-1:0]           hd;

  assign tgt[0] = bus.alu_target;
  assign tgt[1] = bus.fwd_target;
  assign tgt[2] = bus.jmp_target;

  // entry = {tag, result, next_pc}; the jump link value is formed at capture
  assign din[0] = {bus.alu_target, bus.alu_result, DATA_W'(0)};
  assign din[1] = {bus.fwd_target, bus.fwd_result, DATA_W'(0)};
  assign din[2] = {bus.jmp_target, bus.jmp_ori_pc + DATA_W'(4), bus.jmp_next_pc};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign push[g] = (tgt[g] != TAG_INVALID) && !flush;
    assign pop[g]  = gnt_vld && (gnt_id == 2'(g));

    exwb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din[g]),
      .dout  (dout[g]),
      .empty (empty[g]),
      .afull (afull[g]),
      .drop  (drop[g])
    );
  end

  // search starts just past the last winner and wraps
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 2'd0;
    cand    = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      cand = 2'((int'(last_grant) + 1 + i) % NSRC);
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign hd = dout[gnt_id];
  assign bus.almost_full = afull;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.wb_valid   <= 1'b0;
      bus.wb_tag     <= TAG_INVALID;
      bus.wb_result  <= '0;
      bus.wb_is_jump <= 1'b0;
      bus.wb_next_pc <= '0;
      last_grant     <= 2'd2;
    end else if (gnt_vld) begin
      bus.wb_valid   <= 1'b1;
      bus.wb_tag     <= hd[ENT_W-1 -: TAG_W];
      bus.wb_result  <= hd[2*DATA_W-1 -: DATA_W];
      bus.wb_is_jump <= (gnt_id == 2'd2);
      bus.wb_next_pc <= hd[DATA_W-1:0];
      last_grant     <= gnt_id;
    end else begin
      bus.wb_valid   <= 1'b0;
      bus.wb_tag     <= TAG_INVALID;
      bus.wb_result  <= '0;
      bus.wb_is_jump <= 1'b0;
      bus.wb_next_pc <= '0;
    end
  end

  // sticky until reset; flush deliberately leaves it set
  always_ff @(posedge clk) begin
    if (rst)        bus.overflow_err <= 1'b0;
    else if (|drop) bus.overflow_err <= 1'b1;
  end
endmodule

// File: doc/exwb_arbiter.md
Name: exwb_arbiter

Overview:
- Writeback stage that receives the three execute-unit result channels (ALU, forwarder, jump) and serialises them onto the single ROB writeback port.
- The execute units have no ready handshake, so each source gets its own small FIFO.
- Per-source almost-full flags go back to dispatch so it can hold issue before a FIFO overflows.
- Round-robin arbitration among non-empty FIFOs, one writeback per cycle; synchronous flush on misprediction.

Parameters:
- TAG_W, 5, instruction tag width.
- DATA_W, 32, result/PC width.
- DEPTH, 4, entries per source FIFO (power of two, >=2).
- TAG_INVALID, all ones of TAG_W (31), tag value meaning "no result".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  ROB misprediction flush
- alu_target  in  TAG_W  ALU result tag; valid when != TAG_INVALID
- alu_result  in  DATA_W  ALU result
- fwd_target  in  TAG_W  forwarder result tag
- fwd_result  in  DATA_W  forwarder result
- jmp_target  in  TAG_W  jump-unit result tag
- jmp_ori_pc  in  DATA_W  PC of the jump instruction
- jmp_next_pc  in  DATA_W  resolved next PC
- wb_valid  out  1  writeback valid
- wb_tag  out  TAG_W  ROB entry written
- wb_result  out  DATA_W  value written to ROB
- wb_is_jump  out  1  entry came from the jump unit
- wb_next_pc  out  DATA_W  resolved target (jump only, else 0)
- almost_full  out  3  [0]=ALU, [1]=forwarder, [2]=jump; high when FIFO count >= DEPTH-1
- overflow_err  out  1  sticky; an input arrived while its FIFO was full

Behaviour:
- Reset and idle values: all FIFOs empty, wb_valid=0, wb_tag=TAG_INVALID, wb_result=0, wb_is_jump=0, wb_next_pc=0, almost_full=0, overflow_err=0, round-robin last-grant=2 (so ALU has first priority).
- Capture:
  - Each rising edge, every source whose target != TAG_INVALID enqueues {tag, payload} into its own FIFO.
  - All three sources may enqueue in the same cycle.
- Jump link value: jump entries store wb_result = jmp_ori_pc + 4, mod 2^DATA_W (0xFFFFFFFC -> 0x00000000), plus next_pc. Non-jump entries carry next_pc = 0.
- Arbitration:
  - Combinational over FIFO heads.
  - Search order starts at (last_grant+1) mod 3 and wraps.
  - The first non-empty FIFO is granted and dequeued at the edge; last_grant is updated only when a grant occurs.
- Output:
  - Registered. A granted head appears on wb_* the cycle after the grant edge.
  - With no grant, wb_valid=0 and wb_tag=TAG_INVALID.
  - Minimum latency: input valid in cycle N appears on wb_* in cycle N+2.
- Full FIFO:
  - If the same source both dequeues and enqueues on one edge, the input is accepted and the count is unchanged.
  - If it enqueues without a dequeue, the input is dropped, contents are unchanged, and overflow_err is set (cleared only by rst).
- Empty FIFO: never granted. Head contents of an empty FIFO never reach wb_*.
- almost_full is combinational from the registered counts, so it changes the cycle after the count changes.
- Pointer wrap: FIFO read/write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
- Flush, at the edge where flush=1:
  - All FIFOs are cleared, and inputs presented in that cycle are dropped.
  - The wb_* registers return to idle values, so wb_valid=0 the next cycle.
  - last_grant resets to 2.
  - overflow_err is not cleared.
- rst has priority over flush. rst mid-stream discards all pending entries with no writeback.

Test Plan:
- Single ALU result: alu_target=3, alu_result=0x55 in cycle 0 -> wb_valid=1, wb_tag=3, wb_result=0x55, wb_is_jump=0 in cycle 2 only.
- Simultaneous results: ALU tag 1, forwarder tag 2, jump tag 4 (ori_pc=0x100, next_pc=0x200) in cycle 0 -> cycle 2 tag 1, cycle 3 tag 2, cycle 4 tag 4 with wb_result=0x104, wb_next_pc=0x200, wb_is_jump=1.
- Round-robin fairness: ALU and forwarder each fed a new tag every cycle for 8 cycles -> writebacks alternate ALU/forwarder; neither source gets two consecutive grants while the other is non-empty.
- Overflow: jump unit sends tags 1..6 on consecutive cycles while ALU and forwarder are continuously fed to starve it:
  - almost_full[2] rises once the jump FIFO count reaches 3.
  - Each jump input arriving while the jump FIFO is full without a same-cycle jump dequeue is dropped and sets overflow_err.
  - The jump writebacks that do appear are tags 1.. in order, with none of the dropped tags.
- Flush: 3 ALU entries pending, flush=1 in cycle 5 with fwd_target=7 present -> wb_valid=0 from cycle 6 on, tag 7 never written back, almost_full=0.
- Link wrap and reset: jmp_ori_pc=0xFFFFFFFC -> wb_result=0x00000000. rst asserted with 2 entries pending -> all outputs at reset values the next cycle, with no further writebacks.
